// File: rtl/sad_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sad_window_accumulator
// Description : Streams frame/template pixel pairs in candidate-major order,
//               accumulates a 13-bit saturating SAD per candidate position and
//               presents it with a {row,col} tag and a one-cycle valid strobe.
//               Issues a one-cycle clear pulse at search start to preset the
//               downstream minimum tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module sad_window_accumulator #(
    parameter int WIN_W   = 4,
    parameter int WIN_H   = 4,
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        start,
    input  logic [7:0]  frame_pix,
    input  logic [7:0]  window_pix,
    input  logic        pix_valid,
    output logic        clear_min,
    output logic [12:0] sad_out,
    output logic        sad_valid,
    output logic [31:0] tag_out,
    output logic        busy,
    output logic        done
);

    // Pixel counter is at least one bit wide so a 1x1 window still works.
    localparam int          C_WIN_PIX  = WIN_W * WIN_H;
    localparam int          C_CNT_W    = (C_WIN_PIX > 1) ? $clog2(C_WIN_PIX) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_WIN_PIX - 1);
    localparam logic [15:0] C_COL_LAST = 16'(FRAME_W - WIN_W);
    localparam logic [15:0] C_ROW_LAST = 16'(FRAME_H - WIN_H);
    localparam logic [12:0] C_SAD_MAX  = 13'h1FFF;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_ACCUM = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [12:0]        r_acc;
    logic [C_CNT_W-1:0] r_pix_cnt;
    logic [15:0]        r_row;
    logic [15:0]        r_col;
    logic               r_clear_min;
    logic [12:0]        r_sad_out;
    logic               r_sad_valid;
    logic [31:0]        r_tag_out;
    logic               r_busy;
    logic               r_done;

    logic [7:0]         w_absdiff;
    logic [13:0]        w_sum;
    logic [12:0]        w_acc_next;
    logic               w_win_last;
    logic               w_col_last;
    logic               w_row_last;

    // Absolute difference and saturating accumulate; the extra sum bit flags
    // overflow past 8191 so the accumulator clamps instead of wrapping.
    always_comb begin
        w_absdiff  = (frame_pix < window_pix) ? (window_pix - frame_pix)
                                              : (frame_pix - window_pix);
        w_sum      = {1'b0, r_acc} + {6'd0, w_absdiff};
        w_acc_next = w_sum[13] ? C_SAD_MAX : w_sum[12:0];
        w_win_last = (r_pix_cnt == C_CNT_LAST);
        w_col_last = (r_col == C_COL_LAST);
        w_row_last = (r_row == C_ROW_LAST);
    end

    // Search control FSM, accumulator, position counters and registered outputs.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= 13'd0;
            r_pix_cnt   <= '0;
            r_row       <= 16'd0;
            r_col       <= 16'd0;
            r_clear_min <= 1'b0;
            r_sad_out   <= 13'd0;
            r_sad_valid <= 1'b0;
            r_tag_out   <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_clear_min <= 1'b0;
            r_sad_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_CLEAR;
                        r_clear_min <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state   <= S_ACCUM;
                    r_acc     <= 13'd0;
                    r_pix_cnt <= '0;
                    r_row     <= 16'd0;
                    r_col     <= 16'd0;
                end
                S_ACCUM: begin
                    if (pix_valid) begin
                        if (w_win_last) begin
                            // Candidate complete: publish and restart the
                            // accumulator on the same edge (no bubble).
                            r_sad_out   <= w_acc_next;
                            r_tag_out   <= {r_row, r_col};
                            r_sad_valid <= 1'b1;
                            r_acc       <= 13'd0;
                            r_pix_cnt   <= '0;
                            if (w_col_last) begin
                                r_col <= 16'd0;
                                if (w_row_last) begin
                                    r_state <= S_DONE;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_row <= r_row + 16'd1;
                                end
                            end else begin
                                r_col <= r_col + 16'd1;
                            end
                        end else begin
                            r_acc     <= w_acc_next;
                            r_pix_cnt <= r_pix_cnt + C_CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clear_min = r_clear_min;
    assign sad_out   = r_sad_out;
    assign sad_valid = r_sad_valid;
    assign tag_out   = r_tag_out;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sad_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sad_window_accumulator
// Description : Self-checking bench. Instance A (4x4 window, 5x5 frame) runs
//               table-driven searches; instance B (8x8 window, 8x8 frame)
//               covers saturation. Expected SAD/tag records go into per-DUT
//               queues when a search is launched and are popped on sad_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_window_accumulator;

    typedef struct {
        logic [7:0] fa;
        logic [7:0] wa;
        logic [7:0] fb;
        logic [7:0] wb;
        bit         toggle;
        bit         poke;
        int         exp_sad;
        int         exp_gap;
    } vec_t;

    typedef struct {
        logic [12:0] sad;
        logic [31:0] tag;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        start_a, pv_a;
    logic [7:0]  fp_a, wp_a;
    logic        clr_a, sv_a, busy_a, done_a;
    logic [12:0] sad_a;
    logic [31:0] tag_a;

    logic        start_b, pv_b;
    logic [7:0]  fp_b, wp_b;
    logic        clr_b, sv_b, busy_b, done_b;
    logic [12:0] sad_b;
    logic [31:0] tag_b;

    int checks   = 0;
    int failures = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t vecs[5];

    int cyc_a     = 0;
    int strobe_a  = 0;
    int clr_cnt_a = 0;
    int done_cnt_a = 0;
    int last_sv_a = -100;
    int last_clr_a = -100;
    int exp_gap   = 16;

    int cyc_b     = 0;
    int last_sv_b = -100;

    sad_window_accumulator #(.WIN_W(4), .WIN_H(4), .FRAME_W(5), .FRAME_H(5)) u_dut_a (
        .Clk(clk), .Rst_n(rst_n), .start(start_a), .frame_pix(fp_a),
        .window_pix(wp_a), .pix_valid(pv_a), .clear_min(clr_a), .sad_out(sad_a),
        .sad_valid(sv_a), .tag_out(tag_a), .busy(busy_a), .done(done_a)
    );

    sad_window_accumulator #(.WIN_W(8), .WIN_H(8), .FRAME_W(8), .FRAME_H(8)) u_dut_b (
        .Clk(clk), .Rst_n(rst_n), .start(start_b), .frame_pix(fp_b),
        .window_pix(wp_b), .pix_valid(pv_b), .clear_min(clr_b), .sad_out(sad_b),
        .sad_valid(sv_b), .tag_out(tag_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard / protocol monitor for instance A.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc_a++;
            if (sv_a) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_strobe", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    chk("a_sad", 64'(sad_a), 64'(e.sad));
                    chk("a_tag", 64'(tag_a), 64'(e.tag));
                end
                if (last_sv_a > last_clr_a)
                    chk("a_strobe_gap", 64'(cyc_a - last_sv_a), 64'(exp_gap));
                else
                    chk("a_first_latency_ge16", 64'((cyc_a - last_clr_a) >= 16), 64'd1);
                strobe_a++;
                last_sv_a = cyc_a;
            end
            if (clr_a) begin
                chk("a_clear_not_with_valid", 64'(sv_a), 64'd0);
                clr_cnt_a++;
                last_clr_a = cyc_a;
            end
            if (done_a) begin
                chk("a_done_follows_strobe", 64'(cyc_a - last_sv_a), 64'd1);
                done_cnt_a++;
            end
        end
    end

    // Scoreboard monitor for instance B.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc_b++;
            if (sv_b) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_strobe", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    chk("b_sad", 64'(sad_b), 64'(e.sad));
                    chk("b_tag", 64'(tag_b), 64'(e.tag));
                end
                last_sv_b = cyc_b;
            end
            if (done_b)
                chk("b_done_follows_strobe", 64'(cyc_b - last_sv_b), 64'd1);
        end
    end

    task automatic push_a(input int sad);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                q_a.push_back('{sad: 13'(sad), tag: {16'(r), 16'(c)}});
    endtask

    // Full search on instance A driven from one table record.
    task automatic run_a(input vec_t v);
        int  s0, c0, n;
        bit  ph;
        s0 = strobe_a;
        c0 = clr_cnt_a;
        exp_gap = v.exp_gap;
        push_a(v.exp_sad);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_clear_after_start", 64'(clr_a), 64'd1);
        chk("a_busy_in_clear", 64'(busy_a), 64'd1);
        n  = 0;
        ph = 1'b0;
        while (!done_a && n < 400) begin
            fp_a = ph ? v.fb : v.fa;
            wp_a = ph ? v.wb : v.wa;
            pv_a = v.toggle ? (n % 2 == 0) : 1'b1;
            if (v.poke && n == 20)
                start_a = 1'b1;
            else if (v.poke && sv_a && tag_a == 32'h0001_0001)
                start_a = 1'b1;
            else
                start_a = 1'b0;
            ph = ~ph;
            n++;
            @(negedge clk);
        end
        pv_a    = 1'b0;
        start_a = 1'b0;
        chk("a_done_within_budget", 64'(n < 400), 64'd1);
        chk("a_strobe_count", 64'(strobe_a - s0), 64'd4);
        chk("a_busy_at_done", 64'(busy_a), 64'd0);
        repeat (3) @(negedge clk);
        chk("a_single_clear", 64'(clr_cnt_a - c0), 64'd1);
        chk("a_queue_drained", 64'(q_a.size()), 64'd0);
        chk("a_idle_not_busy", 64'(busy_a), 64'd0);
    endtask

    // Single-candidate search on instance B with constant operands.
    task automatic run_b(input logic [7:0] f, input logic [7:0] w, input int exp);
        int n;
        q_b.push_back('{sad: 13'(exp), tag: 32'h0});
        @(negedge clk);
        start_b = 1'b1;
        fp_b = f;
        wp_b = w;
        pv_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_clear_after_start", 64'(clr_b), 64'd1);
        n = 0;
        while (!done_b && n < 300) begin
            n++;
            @(negedge clk);
        end
        pv_b = 1'b0;
        chk("b_done_within_budget", 64'(n < 300), 64'd1);
        chk("b_queue_drained", 64'(q_b.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int s0, d0, n;
        rst_n = 1'b0;
        start_a = 1'b0; pv_a = 1'b0; fp_a = 8'd0; wp_a = 8'd0;
        start_b = 1'b0; pv_b = 1'b0; fp_b = 8'd0; wp_b = 8'd0;

        //          fa      wa      fb      wb    toggle poke  sad   gap
        vecs[0] = '{8'd5,   8'd4,   8'd4,   8'd5,   1'b0, 1'b0, 16,   16};
        vecs[1] = '{8'd10,  8'd3,   8'd3,   8'd10,  1'b0, 1'b0, 112,  16};
        vecs[2] = '{8'd2,   8'd0,   8'd0,   8'd2,   1'b1, 1'b0, 32,   32};
        vecs[3] = '{8'd200, 8'd100, 8'd100, 8'd200, 1'b0, 1'b1, 1600, 16};
        vecs[4] = '{8'd255, 8'd0,   8'd0,   8'd255, 1'b0, 1'b0, 4080, 16};

        repeat (3) @(negedge clk);
        chk("rst_clear_min", 64'(clr_a), 64'd0);
        chk("rst_sad_out",   64'(sad_a), 64'd0);
        chk("rst_sad_valid", 64'(sv_a),  64'd0);
        chk("rst_tag_out",   64'(tag_a), 64'd0);
        chk("rst_busy",      64'(busy_a), 64'd0);
        chk("rst_done",      64'(done_a), 64'd0);
        chk("rst_b_sad_out", 64'(sad_b), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_a(vecs[i]);

        // Reset in the middle of the second candidate.
        push_a(16);
        s0 = strobe_a;
        d0 = done_cnt_a;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        fp_a = 8'd9; wp_a = 8'd8; pv_a = 1'b1;
        n = 0;
        while ((strobe_a - s0) < 1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("mid_first_strobe_seen", 64'(strobe_a - s0), 64'd1);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_clear_min", 64'(clr_a), 64'd0);
        chk("mid_rst_sad_out",   64'(sad_a), 64'd0);
        chk("mid_rst_sad_valid", 64'(sv_a),  64'd0);
        chk("mid_rst_tag_out",   64'(tag_a), 64'd0);
        chk("mid_rst_busy",      64'(busy_a), 64'd0);
        chk("mid_rst_done",      64'(done_a), 64'd0);
        rst_n = 1'b1;
        q_a.delete();
        repeat (40) @(negedge clk);
        pv_a = 1'b0;
        chk("mid_no_more_strobes", 64'(strobe_a - s0), 64'd1);
        chk("mid_no_done",         64'(done_cnt_a - d0), 64'd0);
        run_a(vecs[0]);

        // Saturation boundary on the 8x8 instance.
        run_b(8'd255, 8'd0,   8191);
        run_b(8'd0,   8'd255, 8191);
        run_b(8'd128, 8'd0,   8191);
        run_b(8'd127, 8'd0,   8128);
        run_b(8'd1,   8'd2,   64);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
